// File: rtl/clk_d_latch_with_delay.sv
// Gate-level level-sensitive D latch with explicit inertial gate delays and an
// asynchronous active-high reset. It is a timing-characterisation cell: races,
// glitches and capture-window effects show up on Q/Qb exactly as the netlist produces them.
// Transparent while clk=1, holds while clk=0. Purely level-sensitive; the only
// state is the cross-coupled NAND pair.
`timescale 1ns / 1ps

module clk_d_latch_with_delay #(
    parameter int unsigned NAND_DELAY = 8,
    parameter int unsigned INV_DELAY  = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic D,
    output logic Q,
    output logic Qb
);

    // Internal nets of the fixed netlist.
    logic dn;   // inverted data
    logic rn;   // inverted reset, gates both the set path and the Qb NAND
    logic sn;   // active-low set request
    logic rnn;  // active-low reset request

    // Input inverters.
    assign #(INV_DELAY) dn = ~D;
    assign #(INV_DELAY) rn = ~rst;

    // Steering NANDs: both sit at 1 while clk=0, so the pair below holds.
    // rn on the set path keeps a reset from being overridden by D while clk=1.
    assign #(NAND_DELAY) sn  = ~(D & clk & rn);
    assign #(NAND_DELAY) rnn = ~(dn & clk);

    // Cross-coupled storage pair. rn on the Qb gate forces Qb=1 first on reset,
    // which then pulls Q low through the Q gate.
    assign #(NAND_DELAY) Q  = ~(sn & Qb);
    assign #(NAND_DELAY) Qb = ~(rnn & Q & rn);

endmodule

// File: tb/tb_clk_d_latch_with_delay.sv
// Directed bench for the gate-level D latch: a table of settled-state vectors
// followed by hand-timed sequences around reset, transparency and clk edges.
`timescale 1ns / 1ps

module tb_clk_d_latch_with_delay;

    logic clk;
    logic rst;
    logic d;
    logic q;
    logic qb;

    int checks = 0;
    int errors = 0;

    clk_d_latch_with_delay #(
        .NAND_DELAY(8),
        .INV_DELAY (6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .D  (d),
        .Q  (q),
        .Qb (qb)
    );

    typedef struct {
        logic        rst;
        logic        clk;
        logic        d;
        int unsigned wait_ns;
        logic        exp_q;
        logic        exp_qb;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, actual, expected);
        end
    endtask

    task automatic check_pair(input string name, input logic eq, input logic eqb);
        check({name, ".Q"}, q, eq);
        check({name, ".Qb"}, qb, eqb);
    endtask

    initial begin
        // Settled-state vectors: inputs applied, then 50 ns before sampling.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 50, 1'b0, 1'b1};  // reset, clk low
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 50, 1'b0, 1'b1};  // release with clk low: hold 0
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 50, 1'b1, 1'b0};  // clk rise captures 1
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 50, 1'b0, 1'b1};  // transparent, D=0
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 50, 1'b1, 1'b0};  // transparent, D=1
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 50, 1'b1, 1'b0};  // clk fall holds 1
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 50, 1'b1, 1'b0};  // D ignored while clk low
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 50, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 50, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 50, 1'b0, 1'b1};  // clk rise captures 0
        vecs[10] = '{1'b0, 1'b0, 1'b0, 50, 1'b0, 1'b1};  // clk fall holds 0
        vecs[11] = '{1'b0, 1'b0, 1'b1, 50, 1'b0, 1'b1};  // D ignored while clk low
        vecs[12] = '{1'b0, 1'b1, 1'b1, 50, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 50, 1'b0, 1'b1};  // reset beats transparent D=1
        vecs[14] = '{1'b1, 1'b1, 1'b0, 50, 1'b0, 1'b1};  // D ignored under reset
        vecs[15] = '{1'b1, 1'b0, 1'b1, 50, 1'b0, 1'b1};  // clk ignored under reset
        vecs[16] = '{1'b0, 1'b0, 1'b1, 50, 1'b0, 1'b1};  // release with clk low: hold 0
        vecs[17] = '{1'b0, 1'b1, 1'b1, 50, 1'b1, 1'b0};  // transparent again

        clk = 1'b0;
        rst = 1'b0;
        d   = 1'b0;
        // Wiggle every input once so every gate evaluates, then enter reset.
        #1;
        rst = 1'b1;
        clk = 1'b1;
        d   = 1'b1;
        #2;
        clk = 1'b0;
        d   = 1'b0;
        #47;

        for (int i = 0; i < 18; i++) begin
            rst = vecs[i].rst;
            clk = vecs[i].clk;
            d   = vecs[i].d;
            #(vecs[i].wait_ns);
            check_pair($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_qb);
        end

        // Reset mid-transparent with D=1: Qb rises at +14, Q falls at +22.
        rst = 1'b1;
        #10 check_pair("rst_rise_10", 1'b1, 1'b0);
        #6  check_pair("rst_rise_16", 1'b1, 1'b1);
        #10 check_pair("rst_rise_26", 1'b0, 1'b1);
        #24;
        // Release with clk=1: Q back at +22, Qb low at +30.
        rst = 1'b0;
        #18 check("rst_fall_18.Q", q, 1'b0);
        #8  check("rst_fall_26.Q", q, 1'b1);
        #10 check_pair("rst_fall_36", 1'b1, 1'b0);
        #20;

        // Transparent D fall: Qb rises at +22, Q falls at +30.
        d = 1'b0;
        #18 check_pair("dfall_18", 1'b1, 1'b0);
        #8  check_pair("dfall_26", 1'b1, 1'b1);
        #8  check_pair("dfall_34", 1'b0, 1'b1);
        #30;
        // Transparent D rise: Q rises at +16, Qb falls at +24.
        d = 1'b1;
        #12 check_pair("drise_12", 1'b0, 1'b1);
        #8  check_pair("drise_20", 1'b1, 1'b1);
        #8  check_pair("drise_28", 1'b1, 1'b0);
        #30;

        // clk rise with D differing from the stored 1: Qb at +16, Q at +24.
        clk = 1'b0;
        #50 d = 1'b0;
        #50 check_pair("hold_before_rise", 1'b1, 1'b0);
        clk = 1'b1;
        #12 check("clkrise_12.Qb", qb, 1'b0);
        #8  check_pair("clkrise_20", 1'b1, 1'b1);
        #10 check_pair("clkrise_30", 1'b0, 1'b1);
        #30;

        // 5 ns D pulse while transparent leaves the stored 0 in place.
        d = 1'b1;
        #5 d = 1'b0;
        #60 check_pair("pulse_5ns", 1'b0, 1'b1);

        // D toggles 8 ns after a clk rise: output follows with the normal lag.
        d = 1'b1;
        #50 clk = 1'b0;
        #50 clk = 1'b1;
        #4  check_pair("late_toggle_pre", 1'b1, 1'b0);
        #4  d = 1'b0;
        #45 check_pair("late_toggle_post", 1'b0, 1'b1);

        // D set 20 ns before clk fall is captured and held; later D ignored.
        d = 1'b1;
        #20 clk = 1'b0;
        #60 check_pair("capture_20ns", 1'b1, 1'b0);
        d = 1'b0;
        #100 check_pair("hold_d_low", 1'b1, 1'b0);
        clk = 1'b1;
        #30 check_pair("reopen_30", 1'b0, 1'b1);
        #20;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
